// File: rtl/tia_no_audio_core.sv
// Video-only TIA core: horizontal timer, CPU clock divider, WSYNC/RSYNC,
// vertical sync/blank and background/playfield colour generation.
module tia_no_audio_core #(
  parameter int H_TOTAL     = 228,
  parameter int H_BLANK     = 68,
  parameter int HSYNC_START = 16,
  parameter int HSYNC_END   = 31
) (
  input  logic       osc,
  input  logic       reset_bar,
  input  logic       phi2,
  input  logic [7:0] d,
  input  logic [5:0] a,
  input  logic       rw,
  output logic       blk_bar,
  output logic [2:0] l,
  output logic [3:0] c,
  output logic       syn,
  output logic       rdy,
  output logic       phi_theta
);

  localparam logic [7:0] HMAX = 8'(H_TOTAL - 1);
  localparam logic [7:0] HBLK = 8'(H_BLANK);
  localparam logic [7:0] HS0  = 8'(HSYNC_START);
  localparam logic [7:0] HS1  = 8'(HSYNC_END);

  logic       unused_ok;
  assign unused_ok = phi2;

  logic [7:0] hcount_q, hcount_d;
  logic [1:0] div_q, div_d;
  logic       phi_q, phi_d;
  logic       rw_q, rw_d;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;
  logic [6:0] colupf_q, colupf_d;
  logic [6:0] colubk_q, colubk_d;
  logic       ref_q, ref_d;
  logic [3:0] pf0_q, pf0_d;
  logic [7:0] pf1_q, pf1_d;
  logic [7:0] pf2_q, pf2_d;
  logic       rdy_q, rdy_d;
  logic       blk_q, blk_d;
  logic [2:0] l_q, l_d;
  logic [3:0] c_q, c_d;
  logic       syn_q, syn_d;

  logic        we;
  logic [7:0]  x;
  logic [5:0]  idx, idx_l, idx_m;
  logic [4:0]  k;
  logic [7:0]  pf1_rev;
  logic [19:0] pf_vec;
  logic        pf_bit;
  logic        blank;
  logic [6:0]  col;

  assign we    = rw & ~rw_q;
  assign x     = hcount_q - HBLK;
  assign idx   = x[7:2];
  assign idx_l = idx - 6'd20;
  assign idx_m = 6'd39 - idx;

  // Playfield bits laid out in left-half scan order
  always_comb begin
    pf1_rev = '0;
    for (int b = 0; b < 8; b++) pf1_rev[b] = pf1_q[7-b];
    pf_vec = {pf2_q, pf1_rev, pf0_q};
  end

  always_comb begin
    k = idx[4:0];
    if (idx >= 6'd20) k = ref_q ? idx_m[4:0] : idx_l[4:0];
    pf_bit = (k < 5'd20) ? pf_vec[k] : 1'b0;
  end

  always_comb begin
    hcount_d = (hcount_q == HMAX) ? 8'd0 : hcount_q + 8'd1;
    div_d    = (div_q == 2'd2) ? 2'd0 : div_q + 2'd1;
    phi_d    = (div_q == 2'd2);
    rw_d     = rw;
    vsync_d  = vsync_q;
    vblank_d = vblank_q;
    colupf_d = colupf_q;
    colubk_d = colubk_q;
    ref_d    = ref_q;
    pf0_d    = pf0_q;
    pf1_d    = pf1_q;
    pf2_d    = pf2_q;
    rdy_d    = rdy_q;
    if (we) begin
      unique case (a)
        6'h00:   vsync_d  = d[1];
        6'h01:   vblank_d = d[1];
        6'h02:   rdy_d    = 1'b0;
        6'h03:   hcount_d = 8'd0;
        6'h08:   colupf_d = d[7:1];
        6'h09:   colubk_d = d[7:1];
        6'h0A:   ref_d    = d[0];
        6'h0D:   pf0_d    = d[7:4];
        6'h0E:   pf1_d    = d;
        6'h0F:   pf2_d    = d;
        default: ;
      endcase
    end
    // End-of-line release overrides a same-edge WSYNC
    if (hcount_q == HMAX) rdy_d = 1'b1;
  end

  always_comb begin
    blank = (hcount_q < HBLK) | vblank_q;
    col   = pf_bit ? colupf_q : colubk_q;
    blk_d = ~blank;
    l_d   = blank ? 3'd0 : col[2:0];
    c_d   = blank ? 4'd0 : col[6:3];
    syn_d = vsync_q | ((hcount_q >= HS0) & (hcount_q <= HS1));
  end

  always_ff @(posedge osc or negedge reset_bar) begin
    if (!reset_bar) begin
      hcount_q <= '0;
      div_q    <= '0;
      phi_q    <= 1'b0;
      rw_q     <= 1'b0;
      vsync_q  <= 1'b0;
      vblank_q <= 1'b0;
      colupf_q <= '0;
      colubk_q <= '0;
      ref_q    <= 1'b0;
      pf0_q    <= '0;
      pf1_q    <= '0;
      pf2_q    <= '0;
      rdy_q    <= 1'b1;
      blk_q    <= 1'b0;
      l_q      <= '0;
      c_q      <= '0;
      syn_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      div_q    <= div_d;
      phi_q    <= phi_d;
      rw_q     <= rw_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
      colupf_q <= colupf_d;
      colubk_q <= colubk_d;
      ref_q    <= ref_d;
      pf0_q    <= pf0_d;
      pf1_q    <= pf1_d;
      pf2_q    <= pf2_d;
      rdy_q    <= rdy_d;
      blk_q    <= blk_d;
      l_q      <= l_d;
      c_q      <= c_d;
      syn_q    <= syn_d;
    end
  end

  assign blk_bar   = blk_q;
  assign l         = l_q;
  assign c         = c_q;
  assign syn       = syn_q;
  assign rdy       = rdy_q;
  assign phi_theta = phi_q;

endmodule

// File: tb/tb_tia_no_audio_core.sv
// Bench for tia_no_audio_core: table vectors, corner sequences and a
// randomized run against a behavioural scanline model.
module tb_tia_no_audio_core;

  logic       osc = 1'b0;
  logic       reset_bar;
  logic       phi2;
  logic [7:0] d;
  logic [5:0] a;
  logic       rw;
  logic       blk_bar;
  logic [2:0] l;
  logic [3:0] c;
  logic       syn;
  logic       rdy;
  logic       phi_theta;

  tia_no_audio_core dut (
    .osc(osc), .reset_bar(reset_bar), .phi2(phi2),
    .d(d), .a(a), .rw(rw),
    .blk_bar(blk_bar), .l(l), .c(c), .syn(syn),
    .rdy(rdy), .phi_theta(phi_theta)
  );

  always #5 osc = ~osc;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int   m_h, m_n;
  bit   m_rwq;
  int   r_vsync, r_vblank, r_colupf, r_colubk, r_ctrl;
  int   r_pf0, r_pf1, r_pf2;
  logic m_rdy, e_blk, e_syn, e_phi;
  logic [2:0] e_l;
  logic [3:0] e_c;

  function automatic void model_reset();
    m_h = 0; m_n = 0; m_rwq = 0;
    r_vsync = 0; r_vblank = 0; r_colupf = 0; r_colubk = 0;
    r_ctrl = 0; r_pf0 = 0; r_pf1 = 0; r_pf2 = 0;
    m_rdy = 1; e_blk = 0; e_syn = 0; e_phi = 0; e_l = 0; e_c = 0;
  endfunction

  function automatic int pf_at(int h);
    int xx, i, kk;
    xx = h - 68;
    i = xx / 4;
    if (i < 20) kk = i;
    else if ((r_ctrl & 1) != 0) kk = 19 - (i - 20);
    else kk = i - 20;
    if (kk < 4) return (r_pf0 >> (4 + kk)) & 1;
    if (kk < 12) return (r_pf1 >> (7 - (kk - 4))) & 1;
    return (r_pf2 >> (kk - 12)) & 1;
  endfunction

  function automatic void model_update();
    bit blank, wr;
    int col, nh;
    blank = (m_h < 68) || (((r_vblank >> 1) & 1) != 0);
    col = 0;
    if (!blank) col = (pf_at(m_h) != 0) ? r_colupf : r_colubk;
    e_blk = !blank;
    e_c = blank ? 4'd0 : 4'((col >> 4) & 15);
    e_l = blank ? 3'd0 : 3'((col >> 1) & 7);
    e_syn = (((r_vsync >> 1) & 1) != 0) || (m_h >= 16 && m_h <= 31);
    wr = rw && !m_rwq;
    m_rwq = rw;
    nh = (m_h + 1) % 228;
    if (wr) begin
      case (int'(a))
        'h00: r_vsync = d;
        'h01: r_vblank = d;
        'h02: m_rdy = 0;
        'h03: nh = 0;
        'h08: r_colupf = d;
        'h09: r_colubk = d;
        'h0A: r_ctrl = d;
        'h0D: r_pf0 = d;
        'h0E: r_pf1 = d;
        'h0F: r_pf2 = d;
        default: ;
      endcase
    end
    if (m_h == 227) m_rdy = 1;
    m_h = nh;
    m_n++;
    e_phi = (m_n % 3 == 0);
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (model hcount %0d)", nm, act, exp, m_h);
    end
  endtask

  task automatic tick();
    @(posedge osc);
    model_update();
    @(negedge osc);
    check("tick", {5'd0, blk_bar, l, c, syn, rdy, phi_theta},
          {5'd0, e_blk, e_l, e_c, e_syn, m_rdy, e_phi});
  endtask

  task automatic wr(input logic [5:0] aa, input logic [7:0] dd);
    a = aa; d = dd; rw = 1'b1;
    tick();
    rw = 1'b0;
    tick();
  endtask

  task automatic goto_h(input int h);
    int g;
    g = 0;
    while (m_h != h && g < 500) begin
      tick();
      g++;
    end
    if (m_h != h) check("goto_timeout", 16'(g), 16'd0);
  endtask

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
    int         ph;
    logic       eb;
    logic [2:0] el;
    logic [3:0] ec;
    logic       es;
  } vec_t;

  vec_t tbl[18];
  logic [5:0] addrs[10];

  initial begin
    logic [5:0] pat;
    int cnt;

    tbl[0]  = '{6'h09, 8'h9A, 100, 1'b1, 3'd5, 4'd9, 1'b0};
    tbl[1]  = '{6'h3F, 8'hFF,  20, 1'b0, 3'd0, 4'd0, 1'b1};
    tbl[2]  = '{6'h08, 8'h0E, 100, 1'b1, 3'd5, 4'd9, 1'b0};
    tbl[3]  = '{6'h09, 8'h00, 100, 1'b1, 3'd0, 4'd0, 1'b0};
    tbl[4]  = '{6'h0D, 8'h10,  68, 1'b1, 3'd7, 4'd0, 1'b0};
    tbl[5]  = '{6'h0D, 8'h10,  71, 1'b1, 3'd7, 4'd0, 1'b0};
    tbl[6]  = '{6'h0D, 8'h10,  72, 1'b1, 3'd0, 4'd0, 1'b0};
    tbl[7]  = '{6'h0D, 8'h10, 148, 1'b1, 3'd7, 4'd0, 1'b0};
    tbl[8]  = '{6'h0D, 8'h10, 152, 1'b1, 3'd0, 4'd0, 1'b0};
    tbl[9]  = '{6'h0A, 8'h01, 148, 1'b1, 3'd0, 4'd0, 1'b0};
    tbl[10] = '{6'h0A, 8'h01, 224, 1'b1, 3'd7, 4'd0, 1'b0};
    tbl[11] = '{6'h0A, 8'h01, 227, 1'b1, 3'd7, 4'd0, 1'b0};
    tbl[12] = '{6'h0E, 8'h80,  84, 1'b1, 3'd7, 4'd0, 1'b0};
    tbl[13] = '{6'h0F, 8'h01, 116, 1'b1, 3'd7, 4'd0, 1'b0};
    tbl[14] = '{6'h01, 8'h02, 100, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[15] = '{6'h00, 8'h02, 100, 1'b0, 3'd0, 4'd0, 1'b1};
    tbl[16] = '{6'h00, 8'h00,  50, 1'b0, 3'd0, 4'd0, 1'b0};
    tbl[17] = '{6'h01, 8'h00,  68, 1'b1, 3'd7, 4'd0, 1'b0};
    addrs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h08,
              6'h09, 6'h0A, 6'h0D, 6'h0E, 6'h0F};

    reset_bar = 1'b0; phi2 = 1'b0; rw = 1'b0; a = '0; d = '0;
    model_reset();
    #12;
    check("reset_state", {9'd0, blk_bar, l, c, syn, rdy, phi_theta},
          {9'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0});
    @(negedge osc);
    reset_bar = 1'b1;

    pat = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat[5-i] = phi_theta;
    end
    check("phi_pattern", 16'(pat), 16'(6'b001001));

    for (int i = 0; i < 18; i++) begin
      wr(tbl[i].a, tbl[i].d);
      goto_h(tbl[i].ph);
      tick();
      check($sformatf("tbl%0d", i), {7'd0, blk_bar, l, c, syn},
            {7'd0, tbl[i].eb, tbl[i].el, tbl[i].ec, tbl[i].es});
    end

    goto_h(100);
    a = 6'h02; rw = 1'b1;
    tick();
    check("wsync_halt", 16'(rdy), 16'd0);
    repeat (5) tick();
    check("wsync_hold", 16'(rdy), 16'd0);
    rw = 1'b0;
    goto_h(227);
    check("wsync_pre_wrap", 16'(rdy), 16'd0);
    tick();
    check("wsync_wrap", 16'(rdy), 16'd1);

    goto_h(227);
    a = 6'h02; rw = 1'b1;
    tick();
    check("wsync_at_227", 16'(rdy), 16'd1);
    rw = 1'b0;
    tick();

    goto_h(100);
    a = 6'h03; rw = 1'b1;
    tick();
    rw = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (syn) break;
    end
    check("rsync_syn_delay", 16'(cnt), 16'd17);

    goto_h(50);
    a = 6'h02; rw = 1'b1;
    tick();
    rw = 1'b0;
    check("halt_before_reset", 16'(rdy), 16'd0);
    #2 reset_bar = 1'b0;
    #1;
    check("reset_rdy", 16'(rdy), 16'd1);
    check("reset_outs", {7'd0, blk_bar, l, c, syn},
          {7'd0, 1'b0, 3'd0, 4'd0, 1'b0});
    check("reset_phi", 16'(phi_theta), 16'd0);
    @(negedge osc);
    reset_bar = 1'b1;
    model_reset();

    for (int i = 0; i < 3000; i++) begin
      rw = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) a = 6'($urandom);
      else a = addrs[$urandom_range(0, 9)];
      d = 8'($urandom);
      phi2 = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
